// File: rtl/sched_pkg.sv
// Shared definitions for the output connection scheduler: FSM encoding and a
// one-hot select helper used to pick a single input's flag out of a vector.
package sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONNECT = 2'd1,
    S_RELEASE = 2'd2
  } sched_state_t;

  // Widest requester vector the helper accepts; callers zero-extend to this.
  localparam int ONEHOT_MAX = 64;

  function automatic logic onehot_or(input logic [ONEHOT_MAX-1:0] vec,
                                     input logic [ONEHOT_MAX-1:0] sel);
    return |(vec & sel);
  endfunction

endpackage

// File: rtl/output_conn_scheduler_if.sv
// Bundle of arbiter, flit and crossbar-select signals seen by one output port's
// scheduler. master = scheduler side, slave = surrounding fabric side.
interface output_conn_scheduler_if #(
  parameter int N = 25,
  parameter int P = 8
);

  logic [P*N-1:0] i_port_req;
  logic [P*N-1:0] o_arb_req;
  logic [N-1:0]   i_arb_grant;
  logic [P-1:0]   i_arb_priority;
  logic           o_arb_busy;
  logic           o_arb_rr;
  logic [N-1:0]   i_flit_valid;
  logic [N-1:0]   i_flit_tail;
  logic [N-1:0]   o_flit_ready;
  logic           i_out_ready;
  logic           o_conn_valid;
  logic [N-1:0]   o_conn_grant;
  logic [P-1:0]   o_conn_priority;
  logic           o_timeout;

  modport master (
    input  i_port_req, i_arb_grant, i_arb_priority, i_flit_valid, i_flit_tail, i_out_ready,
    output o_arb_req, o_arb_busy, o_arb_rr, o_flit_ready, o_conn_valid, o_conn_grant,
           o_conn_priority, o_timeout
  );

  modport slave (
    output i_port_req, i_arb_grant, i_arb_priority, i_flit_valid, i_flit_tail, i_out_ready,
    input  o_arb_req, o_arb_busy, o_arb_rr, o_flit_ready, o_conn_valid, o_conn_grant,
           o_conn_priority, o_timeout
  );

endinterface

// File: rtl/output_conn_scheduler_stall_timer.sv
// Counts consecutive no-transfer cycles of a held connection; expire flags the
// last allowed stall cycle and the count holds there instead of wrapping.
module conn_stall_timer #(
  parameter int TIMEOUT = 64,
  localparam int W = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  logic [W-1:0] count;

  assign expire = (count == W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !expire) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/output_conn_scheduler.sv
// Per-output-port connection scheduler: locks one arbiter grant per packet,
// holds the crossbar connection until tail or stall timeout, then releases.
module output_conn_scheduler
  import sched_pkg::*;
#(
  parameter int N       = 25,
  parameter int P       = 8,
  parameter int TIMEOUT = 64
) (
  input logic               clk,
  input logic               reset,
  output_conn_scheduler_if.master bus
);

  sched_state_t state;
  logic [N-1:0] conn_grant;
  logic [P-1:0] conn_priority;
  logic         timeout_q;

  logic         in_idle;
  logic         in_conn;
  logic         lock;
  logic [N-1:0] ready;
  logic         xfer;
  logic         tail;
  logic         expire;
  logic         timeout_fire;

  // Combinational outputs are gated by reset so the port is quiet while held in reset.
  assign in_idle      = reset && (state == S_IDLE);
  assign in_conn      = reset && (state == S_CONNECT);
  assign lock         = in_idle && (|bus.i_arb_grant);
  assign ready        = in_conn ? (conn_grant & {N{bus.i_out_ready}}) : '0;
  assign xfer         = onehot_or(ONEHOT_MAX'(bus.i_flit_valid), ONEHOT_MAX'(ready));
  assign tail         = xfer && onehot_or(ONEHOT_MAX'(bus.i_flit_tail), ONEHOT_MAX'(conn_grant));
  assign timeout_fire = in_conn && !xfer && expire;

  assign bus.o_arb_req       = in_idle ? bus.i_port_req : '0;
  assign bus.o_arb_busy      = lock || in_conn;
  assign bus.o_arb_rr        = lock;
  assign bus.o_flit_ready    = ready;
  assign bus.o_conn_valid    = (state == S_CONNECT);
  assign bus.o_conn_grant    = conn_grant;
  assign bus.o_conn_priority = conn_priority;
  assign bus.o_timeout       = timeout_q;

  conn_stall_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (lock || (in_conn && xfer) || (state == S_RELEASE)),
    .inc    (in_conn && !xfer),
    .expire (expire)
  );

  // Tail wins over an expiring timer because timeout_fire already requires no transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      conn_grant    <= '0;
      conn_priority <= '0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (lock) begin
            state         <= S_CONNECT;
            conn_grant    <= bus.i_arb_grant;
            conn_priority <= bus.i_arb_priority;
          end
        end
        S_CONNECT: begin
          if (tail || timeout_fire) begin
            state         <= S_RELEASE;
            conn_grant    <= '0;
            conn_priority <= '0;
            timeout_q     <= timeout_fire;
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_conn_scheduler.sv
// Directed bench for output_conn_scheduler: lock, flit movement, backpressure,
// stall timeout, tail-on-expiry and reset mid-packet.
module tb_output_conn_scheduler;

  localparam int N       = 25;
  localparam int P       = 8;
  localparam int TIMEOUT = 64;
  localparam logic [P*N-1:0] REQ_PAT = {P{25'h0A51234}};

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  output_conn_scheduler_if #(.N(N), .P(P)) bus ();

  output_conn_scheduler #(
    .N       (N),
    .P       (P),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The arbiter must never present more than one grant at a time.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      assert ($onehot0(bus.i_arb_grant)) else begin
        errors++;
        $error("[TB] FAIL grant_onehot observed %0h expected one-hot or zero", bus.i_arb_grant);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset               = 1'b0;
    bus.i_port_req      = REQ_PAT;
    bus.i_arb_grant     = N'(1) << 3;
    bus.i_arb_priority  = 8'h02;
    bus.i_flit_valid    = '0;
    bus.i_flit_tail     = '0;
    bus.i_out_ready     = 1'b0;

    // 1. reset held with requests present
    repeat (3) tick();
    chk("rst_arb_req",   256'(bus.o_arb_req),    256'(0));
    chk("rst_busy",      256'(bus.o_arb_busy),   256'(0));
    chk("rst_rr",        256'(bus.o_arb_rr),     256'(0));
    chk("rst_conn_val",  256'(bus.o_conn_valid), 256'(0));
    chk("rst_conn_gnt",  256'(bus.o_conn_grant), 256'(0));
    chk("rst_conn_pri",  256'(bus.o_conn_priority), 256'(0));
    chk("rst_ready",     256'(bus.o_flit_ready), 256'(0));
    chk("rst_timeout",   256'(bus.o_timeout),    256'(0));

    reset           = 1'b1;
    bus.i_arb_grant = '0;
    #1;
    chk("idle_arb_req",  256'(bus.o_arb_req), 256'(REQ_PAT));
    chk("idle_busy",     256'(bus.o_arb_busy), 256'(0));
    tick();

    // 2. single four-flit packet from input 5
    bus.i_arb_grant    = N'(1) << 5;
    bus.i_arb_priority = 8'h01;
    bus.i_out_ready    = 1'b1;
    #1;
    chk("lock_busy", 256'(bus.o_arb_busy), 256'(1));
    chk("lock_rr",   256'(bus.o_arb_rr),   256'(1));
    tick();
    bus.i_arb_grant = '0;
    chk("conn_valid", 256'(bus.o_conn_valid),    256'(1));
    chk("conn_grant", 256'(bus.o_conn_grant),    256'(N'(1) << 5));
    chk("conn_pri",   256'(bus.o_conn_priority), 256'(8'h01));
    chk("conn_busy",  256'(bus.o_arb_busy),      256'(1));
    chk("conn_rr",    256'(bus.o_arb_rr),        256'(0));
    chk("conn_req",   256'(bus.o_arb_req),       256'(0));
    for (int k = 1; k <= 4; k++) begin
      bus.i_flit_valid = N'(1) << 5;
      bus.i_flit_tail  = (k == 4) ? (N'(1) << 5) : '0;
      #1;
      chk("pkt_ready", 256'(bus.o_flit_ready), 256'(N'(1) << 5));
      tick();
    end
    bus.i_flit_valid = '0;
    bus.i_flit_tail  = '0;
    chk("rel_valid",   256'(bus.o_conn_valid), 256'(0));
    chk("rel_ready",   256'(bus.o_flit_ready), 256'(0));
    chk("rel_busy",    256'(bus.o_arb_busy),   256'(0));
    chk("rel_req",     256'(bus.o_arb_req),    256'(0));
    chk("rel_gnt",     256'(bus.o_conn_grant), 256'(0));
    chk("rel_timeout", 256'(bus.o_timeout),    256'(0));
    tick();
    chk("back_idle_req", 256'(bus.o_arb_req), 256'(REQ_PAT));

    // 3. backpressure for ten cycles mid-packet
    bus.i_arb_grant    = N'(1) << 2;
    bus.i_arb_priority = 8'h80;
    tick();
    bus.i_arb_grant  = '0;
    bus.i_flit_valid = N'(1) << 2;
    tick();
    bus.i_out_ready = 1'b0;
    repeat (10) tick();
    chk("bp_stall_cnt", 256'(dut.u_timer.count), 256'(10));
    chk("bp_valid",     256'(bus.o_conn_valid),   256'(1));
    chk("bp_ready",     256'(bus.o_flit_ready),   256'(0));
    chk("bp_timeout",   256'(bus.o_timeout),      256'(0));
    chk("bp_pri",       256'(bus.o_conn_priority), 256'(8'h80));
    bus.i_out_ready = 1'b1;
    tick();
    chk("bp_stall_clr", 256'(dut.u_timer.count), 256'(0));
    chk("bp_still_conn", 256'(bus.o_conn_valid), 256'(1));
    bus.i_flit_tail = N'(1) << 2;
    tick();
    bus.i_flit_valid = '0;
    bus.i_flit_tail  = '0;
    chk("bp_rel_valid",   256'(bus.o_conn_valid), 256'(0));
    chk("bp_rel_timeout", 256'(bus.o_timeout),    256'(0));
    tick();

    // 4. connected input never sends: forced release after TIMEOUT cycles
    bus.i_arb_grant = N'(1) << 7;
    bus.i_arb_priority = 8'h04;
    tick();
    bus.i_arb_grant = '0;
    repeat (TIMEOUT - 1) tick();
    chk("to_pre_valid",   256'(bus.o_conn_valid),   256'(1));
    chk("to_pre_cnt",     256'(dut.u_timer.count),  256'(TIMEOUT - 1));
    chk("to_pre_timeout", 256'(bus.o_timeout),      256'(0));
    tick();
    chk("to_rel_valid",   256'(bus.o_conn_valid), 256'(0));
    chk("to_rel_timeout", 256'(bus.o_timeout),    256'(1));
    tick();
    chk("to_pulse_end",   256'(bus.o_timeout),    256'(0));
    chk("to_idle_req",    256'(bus.o_arb_req),    256'(REQ_PAT));

    // 5. tail lands on the expiry cycle
    bus.i_arb_grant = N'(1) << 0;
    bus.i_arb_priority = 8'h10;
    tick();
    bus.i_arb_grant = '0;
    repeat (TIMEOUT - 1) tick();
    chk("te_cnt", 256'(dut.u_timer.count), 256'(TIMEOUT - 1));
    bus.i_flit_valid = N'(1) << 0;
    bus.i_flit_tail  = N'(1) << 0;
    tick();
    bus.i_flit_valid = '0;
    bus.i_flit_tail  = '0;
    chk("te_rel_valid",   256'(bus.o_conn_valid), 256'(0));
    chk("te_rel_timeout", 256'(bus.o_timeout),    256'(0));
    tick();

    // 6. reset after two flits, then relock
    bus.i_arb_grant = N'(1) << 9;
    bus.i_arb_priority = 8'h20;
    tick();
    bus.i_arb_grant  = '0;
    bus.i_flit_valid = N'(1) << 9;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    bus.i_flit_valid = '0;
    chk("mid_rst_valid",   256'(bus.o_conn_valid), 256'(0));
    chk("mid_rst_timeout", 256'(bus.o_timeout),    256'(0));
    chk("mid_rst_gnt",     256'(bus.o_conn_grant), 256'(0));
    reset = 1'b1;
    bus.i_arb_grant = N'(1) << 9;
    #1;
    chk("relock_rr",   256'(bus.o_arb_rr),   256'(1));
    chk("relock_busy", 256'(bus.o_arb_busy), 256'(1));
    tick();
    bus.i_arb_grant = '0;
    chk("relock_valid", 256'(bus.o_conn_valid), 256'(1));
    chk("relock_rr_off", 256'(bus.o_arb_rr),    256'(0));
    chk("relock_gnt",   256'(bus.o_conn_grant), 256'(N'(1) << 9));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
